// File: rtl/alu_pkg.sv
// Shared ALU datapath constants.
package alu_pkg;
  localparam int unsigned WIDTH         = 32;
  localparam int unsigned PREFIX_LEVELS = 5;
  localparam int unsigned PIPE_LATENCY  = 4;
endpackage

// File: rtl/prefix_black_cell.sv
// Kogge-Stone prefix operator: combines a high group (h) with the adjacent lower group (l).
module prefix_black_cell (
  input  logic gh,
  input  logic ph,
  input  logic gl,
  input  logic pl,
  output logic g,
  output logic p
);
  assign g = gh | (ph & gl);
  assign p = ph & pl;
endmodule

// File: rtl/prefix32_pipe_adder.sv
// 32-bit four-stage pipelined Kogge-Stone adder: {cout,s} = a + b + c.
module prefix32_pipe_adder
  import alu_pkg::*;
(
  output logic [WIDTH-1:0] s,
  output logic             cout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             clk,
  input  logic             reset
);
  localparam int S2_LEVELS = 3;
  localparam int SPAN4     = 1 << (PREFIX_LEVELS - 2);
  localparam int SPAN5     = 1 << (PREFIX_LEVELS - 1);

  logic [WIDTH-1:0] a1, b1;
  logic             c1;
  logic [WIDTH-1:0] gen0, prop0;
  logic [S2_LEVELS:0][WIDTH-1:0] gs, ps;
  logic [WIDTH-1:0] g2, p2, bp2;
  logic             c2;
  logic [WIDTH-1:0] g4, p4, g5, p5_unused;
  logic [WIDTH-1:0] g3, bp3;
  logic             c3;

  // Stage 1: operand capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      a1 <= '0;
      b1 <= '0;
      c1 <= 1'b0;
    end else begin
      a1 <= a;
      b1 <= b;
      c1 <= c;
    end
  end

  // Carry-in folded into bit 0's generate, so G[i:0] below equals G[i:-1].
  assign gen0  = a1 & b1;
  assign prop0 = a1 ^ b1;
  assign gs[0] = {gen0[WIDTH-1:1], gen0[0] | (prop0[0] & c1)};
  assign ps[0] = prop0;

  for (genvar lvl = 1; lvl <= S2_LEVELS; lvl++) begin : g_s2_level
    localparam int SPAN = 1 << (lvl - 1);
    for (genvar i = 0; i < WIDTH; i++) begin : g_node
      if (i < SPAN) begin : g_pass
        assign gs[lvl][i] = gs[lvl-1][i];
        assign ps[lvl][i] = ps[lvl-1][i];
      end else begin : g_cell
        prefix_black_cell u_cell (
          .gh(gs[lvl-1][i]), .ph(ps[lvl-1][i]),
          .gl(gs[lvl-1][i-SPAN]), .pl(ps[lvl-1][i-SPAN]),
          .g(gs[lvl][i]), .p(ps[lvl][i])
        );
      end
    end
  end

  // Stage 2: partial prefix (spans 1,2,4) plus bitwise propagate
  always_ff @(posedge clk) begin
    if (!reset) begin
      g2  <= '0;
      p2  <= '0;
      bp2 <= '0;
      c2  <= 1'b0;
    end else begin
      g2  <= gs[S2_LEVELS];
      p2  <= ps[S2_LEVELS];
      bp2 <= prop0;
      c2  <= c1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_level4
    if (i < SPAN4) begin : g_pass
      assign g4[i] = g2[i];
      assign p4[i] = p2[i];
    end else begin : g_cell
      prefix_black_cell u_cell (
        .gh(g2[i]), .ph(p2[i]), .gl(g2[i-SPAN4]), .pl(p2[i-SPAN4]),
        .g(g4[i]), .p(p4[i])
      );
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_level5
    if (i < SPAN5) begin : g_pass
      assign g5[i]        = g4[i];
      assign p5_unused[i] = p4[i];
    end else begin : g_cell
      prefix_black_cell u_cell (
        .gh(g4[i]), .ph(p4[i]), .gl(g4[i-SPAN5]), .pl(p4[i-SPAN5]),
        .g(g5[i]), .p(p5_unused[i])
      );
    end
  end

  // Stage 3: g3[i] is the carry out of bit i
  always_ff @(posedge clk) begin
    if (!reset) begin
      g3  <= '0;
      bp3 <= '0;
      c3  <= 1'b0;
    end else begin
      g3  <= g5;
      bp3 <= bp2;
      c3  <= c2;
    end
  end

  // Stage 4: sum and carry out
  always_ff @(posedge clk) begin
    if (!reset) begin
      s    <= '0;
      cout <= 1'b0;
    end else begin
      s    <= bp3 ^ {g3[WIDTH-2:0], c3};
      cout <= g3[WIDTH-1];
    end
  end
endmodule

// File: tb/tb_prefix32_pipe_adder.sv
// Self-checking bench for prefix32_pipe_adder against a delayed 33-bit sum reference.
module tb_prefix32_pipe_adder;
  import alu_pkg::*;

  logic [31:0] s, a, b;
  logic        cout, c, clk, reset;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [32:0] inflight[$];
  logic [32:0] expv = '0;

  prefix32_pipe_adder dut (
    .s(s), .cout(cout), .a(a), .b(b), .c(c), .clk(clk), .reset(reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; the reference is a plain integer sum delayed PIPE_LATENCY edges.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      inflight.delete();
      expv = '0;
    end else begin
      inflight.push_back({1'b0, a} + {1'b0, b} + {32'b0, c});
      if (inflight.size() == PIPE_LATENCY) expv = inflight.pop_front();
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if ({cout, s} !== 33'h0) begin
        errors++;
        $display("FAIL reset_hold: got cout=%b s=%08h, want cout=0 s=00000000", cout, s);
      end
    end
    reset = 1'b1;
    a = '0; b = '0; c = 1'b0;
    for (int i = 0; i < PIPE_LATENCY; i++) begin
      tick();
      checks++;
      if ({cout, s} !== 33'h0) begin
        errors++;
        $display("FAIL reset_release edge %0d: got cout=%b s=%08h, want 0", i, cout, s);
      end
    end
  endtask

  task automatic test_directed();
    a = 32'h11111111; b = 32'h33333333; c = 1'b1;
    tick();
    a = 32'h44444444; b = 32'h33333333; c = 1'b0;
    tick();
    a = 32'hFFFFFFFF; b = 32'h00000000; c = 1'b1;
    tick();
    a = 32'h80000000; b = 32'h80000000; c = 1'b0;
    tick();
    checks++;
    if ({cout, s} !== {1'b0, 32'h44444445}) begin
      errors++;
      $display("FAIL add_basic: got cout=%b s=%08h, want cout=0 s=44444445", cout, s);
    end
    a = '0; b = '0; c = 1'b0;
    tick();
    checks++;
    if ({cout, s} !== {1'b0, 32'h77777777}) begin
      errors++;
      $display("FAIL add_next: got cout=%b s=%08h, want cout=0 s=77777777", cout, s);
    end
    tick();
    checks++;
    if ({cout, s} !== {1'b1, 32'h00000000}) begin
      errors++;
      $display("FAIL full_ripple: got cout=%b s=%08h, want cout=1 s=00000000", cout, s);
    end
    tick();
    checks++;
    if ({cout, s} !== {1'b1, 32'h00000000}) begin
      errors++;
      $display("FAIL msb_carry: got cout=%b s=%08h, want cout=1 s=00000000", cout, s);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 1000 + PIPE_LATENCY; i++) begin
      if (i < 1000) begin
        a = $urandom; b = $urandom; c = 1'($urandom_range(0, 1));
        if (i % 50 == 7) begin a = 32'hFFFFFFFF; b = $urandom_range(0, 1); end
      end else begin
        a = '0; b = '0; c = 1'b0;
      end
      tick();
      checks++;
      if ({cout, s} !== expv) begin
        errors++;
        $display("FAIL random_stream cycle %0d: got %09h, want %09h", i, {cout, s}, expv);
      end
    end
  endtask

  task automatic test_reset_inflight();
    for (int i = 0; i < 3; i++) begin
      a = $urandom | 32'h1; b = $urandom; c = 1'b1;
      tick();
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({cout, s} !== 33'h0) begin
      errors++;
      $display("FAIL reset_flush: got cout=%b s=%08h, want 0", cout, s);
    end
    reset = 1'b1;
    a = '0; b = '0; c = 1'b0;
    for (int i = 0; i < PIPE_LATENCY + 2; i++) begin
      tick();
      checks++;
      if ({cout, s} !== 33'h0) begin
        errors++;
        $display("FAIL reset_discard edge %0d: got cout=%b s=%08h, want 0", i, cout, s);
      end
    end
  endtask

  initial begin
    a = '0; b = '0; c = 1'b0; reset = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
